phase_stream_generator: RTL and testbench

AXI4-Stream master that produces the 48-bit DDS phase word stream consumed by the ramp envelope logic: `m_axis_tdata_phase[47:35]` drives the envelope phase input. It sits between the configuration registers and the phase/ramp consumers. It runs a phase accumulator with a programmable increment and offset. Stops are aligned to a period boundary, either on request or after a programmed period count, so downstream envelopes always end on a full period.

---
 rtl/phase_stream_generator_pkg.sv | 22 ++
 rtl/phase_stream_generator_phase_accumulator.sv | 40 ++++
 rtl/phase_stream_generator.sv | 148 ++++++++++++++
 tb/tb_phase_stream_generator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_stream_generator_pkg.sv
// ----------------------------------------------------------------------------
// phase_stream_generator_pkg
// Shared constants for the phase stream generator:
//   - default accumulator / period counter widths
//   - FSM state encoding
//   - envelope phase slice of the output phase word
// ----------------------------------------------------------------------------
package phase_stream_generator_pkg;

   localparam int PHASE_WIDTH_DEF = 48;
   localparam int COUNT_WIDTH_DEF = 32;

   // Slice of the phase word that feeds the ramp envelope phase input
   localparam int ENV_PHASE_MSB = 47;
   localparam int ENV_PHASE_LSB = 35;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_RUN      = 2'd1;
   localparam logic [1:0] ST_STOPPING = 2'd2;
   localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/phase_stream_generator_phase_accumulator.sv
// ----------------------------------------------------------------------------
// phase_accumulator
// Phase accumulator register with a full-width-plus-carry adder.
// Ports:
//   clk, aresetn : clock, async active-low reset
//   clr          : synchronous clear of the accumulator (wins over adv)
//   adv          : load acc_next into the accumulator
//   inc          : phase increment
//   acc_next     : acc + inc, modulo 2^W
//   carry        : carry out of acc + inc (period boundary)
// ----------------------------------------------------------------------------
module phase_accumulator #(
   parameter int W = 48
) (
   input  logic         clk,
   input  logic         aresetn,
   input  logic         clr,
   input  logic         adv,
   input  logic [W-1:0] inc,
   output logic [W-1:0] acc_next,
   output logic         carry
);

   logic [W-1:0] acc_q;
   logic [W:0]   sum;

   assign sum      = {1'b0, acc_q} + {1'b0, inc};
   assign acc_next = sum[W-1:0];
   assign carry    = sum[W];

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn)
         acc_q <= '0;
      else if (clr)
         acc_q <= '0;
      else if (adv)
         acc_q <= acc_next;
   end

endmodule

// File: rtl/phase_stream_generator.sv
// ----------------------------------------------------------------------------
// phase_stream_generator
// AXI4-Stream master emitting a DDS phase word stream. tdata = acc + offset,
// acc advances by inc on every beat; a carry out of acc marks the end of a
// period. Streams end only on a period boundary, either after a stop request
// or after cfg_periods periods (0 = unlimited).
// Ports:
//   clk, aresetn          : clock, async active-low reset
//   cfg_phase_inc         : increment per beat (latched on start)
//   cfg_phase_offset      : output offset (latched on start)
//   cfg_periods           : period limit, 0 = unlimited (latched on start)
//   start                 : level, honoured only when idle
//   stop                  : level, honoured only while running
//   m_axis_*_phase        : AXI4-Stream phase output
//   busy                  : stream active (running or draining to a boundary)
//   period_count          : periods completed since the last start
//   wrap                  : one-cycle pulse per completed period
//   done                  : one-cycle pulse when the stream ends
// ----------------------------------------------------------------------------
module phase_stream_generator
   import phase_stream_generator_pkg::*;
#(
   parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
   parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic [PHASE_WIDTH-1:0] cfg_phase_inc,
   input  logic [PHASE_WIDTH-1:0] cfg_phase_offset,
   input  logic [COUNT_WIDTH-1:0] cfg_periods,
   input  logic                   start,
   input  logic                   stop,
   output logic [PHASE_WIDTH-1:0] m_axis_tdata_phase,
   output logic                   m_axis_tvalid_phase,
   input  logic                   m_axis_tready_phase,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] period_count,
   output logic                   wrap,
   output logic                   done
);

   logic [1:0]             state_q;
   logic [PHASE_WIDTH-1:0] inc_q, off_q, tdata_q;
   logic [COUNT_WIDTH-1:0] per_q, cnt_q;
   logic                   tvalid_q, wrap_q, done_q;

   logic                   beat, carry, acc_clr, limit_hit;
   logic [PHASE_WIDTH-1:0] acc_next, tdata_next;
   logic [COUNT_WIDTH-1:0] cnt_inc;

   assign beat       = tvalid_q & m_axis_tready_phase;
   // Hold the accumulator at zero whenever no stream is active, so a start
   // always begins from phase 0 without an explicit load.
   assign acc_clr    = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign tdata_next = acc_next + off_q;
   assign cnt_inc    = cnt_q + COUNT_WIDTH'(1);
   assign limit_hit  = (per_q != '0) && (cnt_inc == per_q);

   phase_accumulator #(.W(PHASE_WIDTH)) u_acc (
      .clk      (clk),
      .aresetn  (aresetn),
      .clr      (acc_clr),
      .adv      (beat),
      .inc      (inc_q),
      .acc_next (acc_next),
      .carry    (carry)
   );

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= ST_IDLE;
         inc_q    <= '0;
         off_q    <= '0;
         per_q    <= '0;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         wrap_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         wrap_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  inc_q    <= cfg_phase_inc;
                  off_q    <= cfg_phase_offset;
                  per_q    <= cfg_periods;
                  cnt_q    <= '0;
                  // acc is zero here, so the first word is the offset itself
                  tdata_q  <= cfg_phase_offset;
                  tvalid_q <= 1'b1;
                  state_q  <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (beat) begin
                  tdata_q <= tdata_next;
                  if (carry) begin
                     wrap_q <= 1'b1;
                     cnt_q  <= cnt_inc;
                     // stop and period limit on the same wrap give one done
                     if (stop || limit_hit) begin
                        tvalid_q <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                     end
                  end else if (stop) begin
                     state_q <= ST_STOPPING;
                  end
               end else if (stop) begin
                  state_q <= ST_STOPPING;
               end
            end
            ST_STOPPING: begin
               if (beat) begin
                  tdata_q <= tdata_next;
                  if (carry) begin
                     wrap_q <= 1'b1;
                     cnt_q  <= cnt_inc;
                  end
                  // A zero increment never reaches a boundary; end on this beat.
                  if (carry || (inc_q == '0)) begin
                     tvalid_q <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q  <= ST_IDLE;
               tvalid_q <= 1'b0;
            end
         endcase
      end
   end

   assign m_axis_tdata_phase  = tdata_q;
   assign m_axis_tvalid_phase = tvalid_q;
   assign busy                = (state_q == ST_RUN) || (state_q == ST_STOPPING);
   assign period_count        = cnt_q;
   assign wrap                = wrap_q;
   assign done                = done_q;

endmodule

// File: tb/tb_phase_stream_generator.sv
module tb_phase_stream_generator;

   localparam int PW = 48;
   localparam int CW = 32;

   localparam logic [PW-1:0] P44 = 48'h1000_0000_0000;
   localparam logic [PW-1:0] P45 = 48'h2000_0000_0000;
   localparam logic [PW-1:0] P46 = 48'h4000_0000_0000;
   localparam logic [PW-1:0] P47 = 48'h8000_0000_0000;

   logic          clk = 1'b0;
   logic          aresetn = 1'b0;
   logic [PW-1:0] cfg_phase_inc = '0;
   logic [PW-1:0] cfg_phase_offset = '0;
   logic [CW-1:0] cfg_periods = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          tready = 1'b0;
   logic [PW-1:0] tdata;
   logic          tvalid, busy, wrap, done;
   logic [CW-1:0] period_count;

   int n_chk = 0;
   int n_err = 0;
   int n_beats = 0, n_wraps = 0, n_dones = 0;
   int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready

   phase_stream_generator #(.PHASE_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
      .clk                 (clk),
      .aresetn             (aresetn),
      .cfg_phase_inc       (cfg_phase_inc),
      .cfg_phase_offset    (cfg_phase_offset),
      .cfg_periods         (cfg_periods),
      .start               (start),
      .stop                (stop),
      .m_axis_tdata_phase  (tdata),
      .m_axis_tvalid_phase (tvalid),
      .m_axis_tready_phase (tready),
      .busy                (busy),
      .period_count        (period_count),
      .wrap                (wrap),
      .done                (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial forever begin
      @(posedge clk); #1;
      case (rdy_mode)
         0:       tready = 1'b1;
         1:       tready = ($urandom % 3) != 0;
         default: tready = 1'b0;
      endcase
   end

   // Reference model: a transaction-level view of the stream. Each negedge it
   // compares the current outputs, then predicts what the next edge produces
   // from the inputs the DUT is about to sample.
   logic [PW-1:0] m_acc, m_inc, m_off, m_tdata;
   logic [CW-1:0] m_per, m_cnt;
   logic [PW:0]   m_sum;
   logic          m_valid = 1'b0, m_wrap = 1'b0, m_done = 1'b0, m_pend = 1'b0, m_last;
   int            m_act = 0;  // 0 idle, 1 streaming, 2 just finished

   always @(negedge clk) begin
      if (!aresetn) begin
         m_act = 0; m_valid = 1'b0; m_wrap = 1'b0; m_done = 1'b0;
         m_cnt = '0; m_pend = 1'b0; m_acc = '0;
      end else begin
         chk("tvalid", tvalid, m_valid);
         if (m_valid) chk("tdata", tdata, m_tdata);
         chk("wrap", wrap, m_wrap);
         chk("done", done, m_done);
         chk("busy", busy, m_act == 1);
         chk("period_count", period_count, m_cnt);
         if (tvalid && tready) n_beats++;
         if (wrap) n_wraps++;
         if (done) n_dones++;
         m_wrap = 1'b0;
         m_done = 1'b0;
         if (m_act == 1) begin
            if (tready) begin
               m_last = 1'b0;
               m_sum  = {1'b0, m_acc} + {1'b0, m_inc};
               if (m_sum[PW]) begin
                  m_cnt  = m_cnt + 1;
                  m_wrap = 1'b1;
                  m_last = m_pend || stop || (m_per != 0 && m_cnt == m_per);
               end else if (m_pend && m_inc == 0) begin
                  m_last = 1'b1;
               end
               m_acc   = m_sum[PW-1:0];
               m_tdata = m_acc + m_off;
               if (stop) m_pend = 1'b1;
               if (m_last) begin
                  m_act = 2; m_valid = 1'b0; m_done = 1'b1;
               end
            end else if (stop) begin
               m_pend = 1'b1;
            end
         end else if (m_act == 2) begin
            m_act = 0;
         end else if (start) begin
            m_act = 1; m_valid = 1'b1; m_pend = 1'b0;
            m_inc = cfg_phase_inc; m_off = cfg_phase_offset; m_per = cfg_periods;
            m_acc = '0; m_cnt = '0; m_tdata = cfg_phase_offset;
         end
      end
   end

   task automatic clr_counts();
      n_beats = 0; n_wraps = 0; n_dones = 0;
   endtask

   task automatic run_start(input logic [PW-1:0] inc, input logic [PW-1:0] off,
                            input logic [CW-1:0] per);
      @(posedge clk); #1;
      clr_counts();
      cfg_phase_inc = inc; cfg_phase_offset = off; cfg_periods = per;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      for (int c = 0; c < bound && n_dones == 0; c++) begin
         @(posedge clk); #1;
      end
      chk(tag, n_dones > 0, 1);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_beats(input string tag, input int n, input int bound);
      for (int c = 0; c < bound && n_beats < n; c++) begin
         @(posedge clk); #1;
      end
      chk(tag, n_beats >= n, 1);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
   endtask

   initial begin
      logic [PW-1:0] r_inc, r_off;
      int b;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", period_count, 0);
      chk("rst_tdata", tdata, 0);
      chk("rst_pulses", {wrap, done}, 0);
      aresetn = 1'b1;

      // basic two-period run, always ready
      rdy_mode = 0;
      run_start(P44, '0, 2);
      wait_done("t1_done_seen", 200);
      chk("t1_beats", n_beats, 32);
      chk("t1_wraps", n_wraps, 2);
      chk("t1_dones", n_dones, 1);
      chk("t1_count", period_count, 2);
      chk("t1_tvalid", tvalid, 0);

      // same with stalls
      rdy_mode = 1;
      run_start(P44, '0, 2);
      wait_done("t2_done_seen", 600);
      chk("t2_beats", n_beats, 32);
      chk("t2_wraps", n_wraps, 2);
      chk("t2_count", period_count, 2);

      // stop mid-period drains to the boundary
      rdy_mode = 0;
      run_start(P45, '0, 0);
      wait_beats("t3_beats3", 3, 50);
      pulse_stop();
      wait_done("t3_done_seen", 100);
      chk("t3_beats", n_beats, 8);
      chk("t3_count", period_count, 1);
      chk("t3_dones", n_dones, 1);

      // stop coinciding with the period-limit wrap
      run_start(P46, '0, 1);
      wait_beats("t3b_beats3", 3, 50);
      pulse_stop();
      wait_done("t3b_done_seen", 100);
      chk("t3b_beats", n_beats, 4);
      chk("t3b_dones", n_dones, 1);
      chk("t3b_count", period_count, 1);

      // offset added after the boundary test
      run_start(P46, P47, 3);
      chk("t4_w0", tdata, P47);
      @(posedge clk); #1;
      chk("t4_w1", tdata, P46 + P47);
      @(posedge clk); #1;
      chk("t4_w2", tdata, 0);
      @(posedge clk); #1;
      chk("t4_w3", tdata, P46);
      wait_done("t4_done_seen", 100);
      chk("t4_beats", n_beats, 12);
      chk("t4_wraps", n_wraps, 3);

      // asynchronous reset mid-run with the consumer stalled
      run_start(P44, 48'h123, 0);
      for (int c = 0; c < 100 && n_wraps == 0; c++) begin
         @(posedge clk); #1;
      end
      rdy_mode = 2;
      repeat (3) @(posedge clk);
      #1;
      chk("t5_pre_busy", busy, 1);
      chk("t5_pre_count_nz", period_count != 0, 1);
      @(posedge clk); #2;
      aresetn = 1'b0;
      #1;
      chk("t5_tvalid", tvalid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_count", period_count, 0);
      chk("t5_tdata", tdata, 0);
      @(posedge clk); #1;
      aresetn = 1'b1;
      rdy_mode = 0;
      run_start(P44, '0, 2);
      wait_done("t5_after_done_seen", 200);
      chk("t5_after_beats", n_beats, 32);
      chk("t5_after_count", period_count, 2);

      // zero increment: stop gives exactly one more beat; start while busy ignored
      run_start('0, 48'hABC, 0);
      repeat (4) @(posedge clk);
      #1;
      cfg_phase_inc = P45; cfg_phase_offset = 48'h55; cfg_periods = 1;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b0;
      chk("t6_tdata_kept", tdata, 48'hABC);
      b = n_beats;
      pulse_stop();
      wait_done("t6_done_seen", 50);
      chk("t6_beats", n_beats, b + 2);
      chk("t6_count", period_count, 0);

      // randomized runs with stalls, stops and ignored start pulses
      rdy_mode = 1;
      for (int i = 0; i < 8; i++) begin
         r_inc = (48'($urandom_range(1, 255)) << 40) | 48'($urandom);
         r_off = {16'($urandom), 32'($urandom)};
         run_start(r_inc, r_off, 32'($urandom_range(0, 3)));
         for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            if (n_dones != 0) break;
            stop  = ($urandom % 64) == 0;
            start = ($urandom % 16) == 0;
            cfg_phase_inc = {16'($urandom), 32'($urandom)};
         end
         start = 1'b0;
         stop  = 1'b0;
         chk("rnd_done_seen", n_dones > 0, 1);
         repeat (3) @(posedge clk);
         #1;
         chk("rnd_dones", n_dones, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
